// File: rtl/butterfly_pipe.sv
`timescale 1ns/1ps
// butterfly_pipe
// Three-stage pipelined modular butterfly for the NTT/INTT datapath.
//   ct_mode_i = 1 : Cooley-Tukey    a' = a + w*b,  b' = a - w*b      (mod Q)
//   ct_mode_i = 0 : Gentleman-Sande a' = a + b,    b' = (a - b) * w  (mod Q)
// Stages: S1 operand capture, S2 multiply (GS add/sub feeds the multiplier),
// S3 reduction, CT final add/sub and the optional halving. The S3 registers
// drive the outputs directly, so latency is exactly three cycles.
//
// Optional feature macro: BUTTERFLY_HALVE_EN
//   When defined, both GS results are multiplied by 2^-1 mod Q inside S3
//   (x even -> x>>1, x odd -> (x+Q)>>1). CT results are never halved.
//
// Handshake: an input beat transfers on a rising edge where valid_i & ready_o;
// an output beat transfers where valid_o & ready_i. The whole pipe advances on
// en = ready_i | ~valid_o and ready_o = en, so a refused output freezes every
// stage (data and valid bits alike) and keeps a_o/b_o/tag_o/valid_o stable
// until it is taken. Dropping ready_i while valid_o = 0 changes nothing, and
// back-to-back input with ready_i high streams one result per cycle.
module butterfly_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned Q      = 8380417,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              ct_mode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] Q_D = DATA_W'(Q);
  localparam logic [PROD_W-1:0] Q_P = PROD_W'(Q);

  // Modular add of two values in [0,Q); DATA_W holds 2Q-1, so no carry is lost.
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] s;
    s = x + y;
    return (s >= Q_D) ? (s - Q_D) : s;
  endfunction

  // Modular subtract; a negative difference wraps by adding Q first.
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    return (x >= y) ? (x - y) : (x + Q_D - y);
  endfunction

`ifdef BUTTERFLY_HALVE_EN
  // Multiply by 2^-1 mod Q: odd values get Q added so the shift is exact.
  function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x);
    return x[0] ? ((x + Q_D) >> 1) : (x >> 1);
  endfunction
`endif

  // Global advance enable shared by every stage.
  logic en;
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  // S1 registers: raw operands with their mode and tag.
  logic              s1_valid;
  logic              s1_ct;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_w;

  // S2 registers: the additive term (CT: a, GS: a+b) and the full product.
  logic              s2_valid;
  logic              s2_ct;
  logic [TAG_W-1:0]  s2_tag;
  logic [DATA_W-1:0] s2_a;
  logic [PROD_W-1:0] s2_prod;

  // S2 combinational terms.
  logic [DATA_W-1:0] gs_sum;
  logic [DATA_W-1:0] gs_diff;
  logic [DATA_W-1:0] mul_op;
  logic [PROD_W-1:0] prod;

  // S3 combinational terms.
  logic [DATA_W-1:0] red;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;

  // S1: capture an accepted beat; the valid bit follows valid_i whenever en.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_ct    <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_w     <= '0;
    end else if (en) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_ct  <= ct_mode_i;
        s1_tag <= tag_i;
        s1_a   <= a_i;
        s1_b   <= b_i;
        s1_w   <= w_i;
      end
    end
  end

  // S2 datapath: GS forms a+b and a-b; the multiplier takes b (CT) or a-b (GS).
  always_comb begin
    gs_sum  = mod_add(s1_a, s1_b);
    gs_diff = mod_sub(s1_a, s1_b);
    mul_op  = s1_ct ? s1_b : gs_diff;
    prod    = PROD_W'(mul_op) * PROD_W'(s1_w);
  end

  // S2: register the full-width product and the additive term.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_ct    <= 1'b0;
      s2_tag   <= '0;
      s2_a     <= '0;
      s2_prod  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ct   <= s1_ct;
        s2_tag  <= s1_tag;
        s2_a    <= s1_ct ? s1_a : gs_sum;
        s2_prod <= prod;
      end
    end
  end

  // S3 datapath: reduce the product, then CT add/sub or GS pass-through/halve.
  always_comb begin
    red = DATA_W'(s2_prod % Q_P);
    if (s2_ct) begin
      res_a = mod_add(s2_a, red);
      res_b = mod_sub(s2_a, red);
    end else begin
`ifdef BUTTERFLY_HALVE_EN
      res_a = halve(s2_a);
      res_b = halve(red);
`else
      res_a = s2_a;
      res_b = red;
`endif
    end
  end

  // S3: output registers; they hold while the downstream refuses the beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      tag_o   <= '0;
      a_o     <= '0;
      b_o     <= '0;
    end else if (en) begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        tag_o <= s2_tag;
        a_o   <= res_a;
        b_o   <= res_b;
      end
    end
  end

endmodule
